// File: rtl/mpu_ctrl_datapath_if.sv
// rtl/mpu_ctrl_datapath_if.sv - signal bundle between CPU control logic and the MPU support block
//
// Purpose: groups the power-request, accumulator and serializer signals of
//          mpu_ctrl_datapath so that they travel as one port.
// Signals:
//   sleep_request / wakeup_request  power-state requests from the CPU side
//   cpu_state                       current power state (00 IDLE, 01 ACTIVE, 10 SLEEP, 11 WAKEUP)
//   acc_data / acc_i / acc_o        addend, base operand, registered sum
//   spi_data_in / spi_start         parallel word and load strobe
//   spi_data_o / spi_busy / spi_done serial MOSI bit, shifting flag, end-of-word pulse
// Modports: master drives the requests and operands, slave is the datapath.
interface mpu_ctrl_datapath_if #(
  parameter int WORD = 8
);
  logic            sleep_request;
  logic            wakeup_request;
  logic [1:0]      cpu_state;
  logic [WORD-1:0] acc_data;
  logic [WORD-1:0] acc_i;
  logic [WORD-1:0] acc_o;
  logic [WORD-1:0] spi_data_in;
  logic            spi_start;
  logic            spi_data_o;
  logic            spi_busy;
  logic            spi_done;

  modport master (
    output sleep_request, wakeup_request, acc_data, acc_i, spi_data_in, spi_start,
    input  cpu_state, acc_o, spi_data_o, spi_busy, spi_done
  );

  modport slave (
    input  sleep_request, wakeup_request, acc_data, acc_i, spi_data_in, spi_start,
    output cpu_state, acc_o, spi_data_o, spi_busy, spi_done
  );
endinterface

// File: rtl/mpu_ctrl_datapath.sv
// rtl/mpu_ctrl_datapath.sv - MPU power-state FSM, gated accumulator and MSB-first SPI serializer
//
// Purpose: one clock / one reset block holding
//   - the CPU power-state machine IDLE -> ACTIVE <-> SLEEP -> WAKEUP -> ACTIVE,
//   - a WORD-bit wrap-around accumulate stage that only updates in ACTIVE,
//   - a parallel-to-serial shifter driving MOSI, independent of the power state.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high; clears all state and aborts any sequence
//   bus    mpu_ctrl_datapath_if.slave (requests, operands, cpu_state, acc_o, SPI signals)
module mpu_ctrl_datapath #(
  parameter int WORD        = 8,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  mpu_ctrl_datapath_if.slave  bus
);

  localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam int BCW = $clog2(WORD + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_SLEEP  = 2'b10,
    ST_WAKEUP = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WCW-1:0]   r_wcnt;
  logic [WCW-1:0]   w_wcnt_nxt;

  logic [WORD-1:0]  r_acc;

  logic [WORD-1:0]  r_shift;
  logic [BCW-1:0]   r_bcnt;
  logic             r_busy;
  logic             r_done;

  // ---------------- power-state FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: begin
        // wakeup_request wins when both requests are raised together
        if (bus.sleep_request && !bus.wakeup_request) begin
          w_state_nxt = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (bus.wakeup_request) begin
          w_state_nxt = ST_WAKEUP;
          w_wcnt_nxt  = WCW'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKEUP: begin
        // counter values WAKE_CYCLES-1 .. 0 each occupy one cycle
        if (r_wcnt == '0) begin
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_wcnt_nxt = r_wcnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.cpu_state = r_state;

  // ---------------- accumulator ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (r_state == ST_ACTIVE) begin
      r_acc <= bus.acc_i + bus.acc_data;
    end
  end

  assign bus.acc_o = r_acc;

  // ---------------- serializer ----------------
  // The done cycle has r_busy low, so a start sampled then is accepted and
  // the next word begins right after the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_bcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_shift <= {r_shift[WORD-2:0], 1'b0};
        r_bcnt  <= r_bcnt - 1'b1;
        if (r_bcnt == BCW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (bus.spi_start) begin
        r_shift <= bus.spi_data_in;
        r_bcnt  <= BCW'(WORD);
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.spi_data_o = r_busy & r_shift[WORD-1];
  assign bus.spi_busy   = r_busy;
  assign bus.spi_done   = r_done;

endmodule

// File: tb/tb_mpu_ctrl_datapath.sv
// tb/tb_mpu_ctrl_datapath.sv - directed self-checking bench for mpu_ctrl_datapath
module tb_mpu_ctrl_datapath;

  logic clk;
  logic reset;

  mpu_ctrl_datapath_if #(.WORD(8)) bus ();

  mpu_ctrl_datapath #(.WORD(8), .WAKE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_check(input string tag, input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {31'd0, bus.spi_busy}, 32'd1);
      check({tag, "_bit"}, {31'd0, bus.spi_data_o}, {31'd0, word[7-i]});
      step();
    end
  endtask

  logic [7:0] model;
  logic [7:0] w;

  initial begin
    reset              = 1'b1;
    bus.sleep_request  = 1'b0;
    bus.wakeup_request = 1'b0;
    bus.acc_data       = '0;
    bus.acc_i          = '0;
    bus.spi_data_in    = '0;
    bus.spi_start      = 1'b0;

    // 1. reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_state", {30'd0, bus.cpu_state}, 32'd0);
    end
    check("rst_acc", {24'd0, bus.acc_o}, 32'd0);
    check("rst_mosi", {31'd0, bus.spi_data_o}, 32'd0);
    check("rst_busy", {31'd0, bus.spi_busy}, 32'd0);
    check("rst_done", {31'd0, bus.spi_done}, 32'd0);
    reset = 1'b0;
    step();
    check("idle_to_active", {30'd0, bus.cpu_state}, 32'd1);

    // 2. running sum of 4, then wrap
    model = 8'd0;
    bus.acc_data = 8'd4;
    for (int i = 0; i < 5; i++) begin
      bus.acc_i = model;
      step();
      model = model + 8'd4;
      check("acc_sum", {24'd0, bus.acc_o}, {24'd0, model});
    end
    check("acc_20", {24'd0, bus.acc_o}, 32'd20);
    bus.acc_i = 8'hFF; bus.acc_data = 8'h02;
    step();
    check("acc_wrap", {24'd0, bus.acc_o}, 32'h01);

    // 3. sleep / wakeup
    bus.acc_i = 8'h10; bus.acc_data = 8'h01;
    bus.sleep_request = 1'b1;
    step();
    bus.sleep_request = 1'b0;
    check("to_sleep", {30'd0, bus.cpu_state}, 32'd2);
    check("acc_last_active", {24'd0, bus.acc_o}, 32'h11);
    bus.acc_i = 8'h20;
    for (int i = 0; i < 2; i++) begin
      step();
      check("sleep_hold", {30'd0, bus.cpu_state}, 32'd2);
      check("sleep_acc_frozen", {24'd0, bus.acc_o}, 32'h11);
    end
    bus.wakeup_request = 1'b1;
    step();
    bus.wakeup_request = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wakeup_state", {30'd0, bus.cpu_state}, 32'd3);
      check("wakeup_acc_frozen", {24'd0, bus.acc_o}, 32'h11);
      step();
    end
    check("wake_to_active", {30'd0, bus.cpu_state}, 32'd1);
    check("acc_not_yet", {24'd0, bus.acc_o}, 32'h11);
    step();
    check("acc_resume", {24'd0, bus.acc_o}, 32'h21);
    bus.sleep_request = 1'b1; bus.wakeup_request = 1'b1;
    step();
    check("both_req_stay", {30'd0, bus.cpu_state}, 32'd1);
    step();
    check("both_req_stay2", {30'd0, bus.cpu_state}, 32'd1);
    bus.sleep_request = 1'b0; bus.wakeup_request = 1'b0;

    // 4. serialize 0x08
    bus.spi_data_in = 8'h08; bus.spi_start = 1'b1;
    step();
    bus.spi_start = 1'b0;
    shift_check("s08", 8'h08);
    check("s08_done", {31'd0, bus.spi_done}, 32'd1);
    check("s08_done_busy", {31'd0, bus.spi_busy}, 32'd0);
    check("s08_done_mosi", {31'd0, bus.spi_data_o}, 32'd0);
    step();
    check("s08_done_once", {31'd0, bus.spi_done}, 32'd0);
    check("s08_idle_mosi", {31'd0, bus.spi_data_o}, 32'd0);

    // 5. restart ignored mid-shift, then back-to-back 0xA5
    bus.spi_data_in = 8'h08; bus.spi_start = 1'b1;
    step();
    bus.spi_start = 1'b0;
    w = 8'h08;
    for (int i = 0; i < 8; i++) begin
      check("s5_busy", {31'd0, bus.spi_busy}, 32'd1);
      check("s5_bit", {31'd0, bus.spi_data_o}, {31'd0, w[7-i]});
      if (i == 2) begin
        bus.spi_data_in = 8'hFF; bus.spi_start = 1'b1;
      end else begin
        bus.spi_start = 1'b0;
      end
      step();
    end
    bus.spi_start = 1'b0;
    check("s5_done", {31'd0, bus.spi_done}, 32'd1);
    bus.spi_data_in = 8'hA5; bus.spi_start = 1'b1;
    step();
    bus.spi_start = 1'b0;
    shift_check("sA5", 8'hA5);
    check("sA5_done", {31'd0, bus.spi_done}, 32'd1);
    step();

    // 6. reset mid-shift and during WAKEUP
    bus.sleep_request = 1'b1;
    step();
    bus.sleep_request = 1'b0;
    check("s6_sleep", {30'd0, bus.cpu_state}, 32'd2);
    bus.wakeup_request = 1'b1;
    bus.spi_data_in = 8'hC3; bus.spi_start = 1'b1;
    step();
    bus.wakeup_request = 1'b0; bus.spi_start = 1'b0;
    step(); step(); step();
    check("s6_in_wakeup", {30'd0, bus.cpu_state}, 32'd3);
    check("s6_bit3_busy", {31'd0, bus.spi_busy}, 32'd1);
    check("s6_bit3", {31'd0, bus.spi_data_o}, 32'd0);
    reset = 1'b1;
    step();
    check("s6_rst_busy", {31'd0, bus.spi_busy}, 32'd0);
    check("s6_rst_mosi", {31'd0, bus.spi_data_o}, 32'd0);
    check("s6_rst_state", {30'd0, bus.cpu_state}, 32'd0);
    check("s6_rst_done", {31'd0, bus.spi_done}, 32'd0);
    check("s6_rst_acc", {24'd0, bus.acc_o}, 32'd0);
    reset = 1'b0;
    step();
    check("s6_rel_active", {30'd0, bus.cpu_state}, 32'd1);
    check("s6_rel_idle_spi", {31'd0, bus.spi_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mpu_ctrl_datapath.md
Name: mpu_ctrl_datapath

Overview:
Small MPU support block that groups three functions behind one clock and one reset:
- CPU power-state FSM (idle/active/sleep/wakeup).
- 8-bit accumulate stage, gated by the FSM.
- MSB-first parallel-to-serial shifter that feeds the SPI MOSI line.

It sits between the CPU control logic and the serial peripherals.

Parameters:
WORD, 8, width of the accumulator datapath and of the serializer word
WAKE_CYCLES, 4, number of cycles spent in WAKEUP before returning to ACTIVE (minimum 1)

Ports:
clk  input  1  system clock (16 MHz nominal); all logic is on the rising edge
reset  input  1  synchronous, active-high reset
sleep_request  input  1  request to enter SLEEP
wakeup_request  input  1  request to leave SLEEP
cpu_state  output  2  current FSM state: 00 IDLE, 01 ACTIVE, 10 SLEEP, 11 WAKEUP
acc_data  input  WORD  addend
acc_i  input  WORD  accumulator feedback/base operand
acc_o  output  WORD  registered sum
spi_data_in  input  WORD  parallel word to serialize
spi_start  input  1  load/start strobe
spi_data_o  output  1  serial data out (MOSI)
spi_busy  output  1  high while shifting
spi_done  output  1  one-cycle pulse after the last bit

Behaviour:
Reset:
- One clock; reset is synchronous and active-high: sampled only on the rising edge of clk. When high, all state is cleared on that edge.
- Reset values: cpu_state=00, acc_o=0, spi_data_o=0, spi_busy=0, spi_done=0, shift register=0, bit counter=0, wake counter=0.
- Reset asserted mid-operation aborts any shift or wakeup sequence; reset has priority over every other input.

CPU FSM (state register drives cpu_state directly):
- IDLE -> ACTIVE unconditionally on the first edge after reset is released.
- ACTIVE: sleep_request=1 and wakeup_request=0 -> SLEEP. If both are 1, stay in ACTIVE (wakeup has priority). Otherwise stay.
- SLEEP: wakeup_request=1 -> WAKEUP and load wake counter with WAKE_CYCLES-1. sleep_request is ignored in SLEEP.
- WAKEUP: decrement the counter each cycle. When the counter reaches 0, go to ACTIVE. Requests are ignored during WAKEUP. Total residency is exactly WAKE_CYCLES cycles.
- Encoding 11 is reachable only as WAKEUP; there are no illegal states.

Accumulator:
- When cpu_state==ACTIVE: acc_o <= (acc_i + acc_data) mod 2^WORD. Carry is discarded (wrap-around), e.g. 0xFF+0x02 -> 0x01.
- In any other state acc_o holds its value.
- Latency is 1 cycle from operands to acc_o.
- acc_o is intended to be fed back into acc_i externally to form a running sum.

Serializer (independent of cpu_state):
- Idle (spi_busy=0): spi_start=1 on an edge loads spi_data_in into the shift register, sets the bit counter to WORD, and sets spi_busy=1.
- While busy, spi_data_o = shift register MSB.
- Each edge while busy: shift left by 1 (zero fill) and decrement the counter.
- Bit i (MSB first) is valid during the i-th cycle after the load edge; each bit is held exactly one clk.
- When the counter reaches 0: spi_busy=0 and spi_done=1 for exactly one cycle, with spi_data_o=0.
- spi_start while busy is ignored; there is no restart and no queuing.
- spi_start on the same edge as done is accepted (back-to-back words), and the new word's MSB follows immediately.
- While idle, spi_data_o=0.

Test Plan:
1. Reset held 3 cycles, then released -> cpu_state 00 during reset, 01 on the first edge after release; acc_o=0, spi_data_o=0, spi_busy=0.
2. In ACTIVE, acc_data=4 and acc_o looped back into acc_i for 5 cycles -> acc_o sequence 4, 8, 12, 16, 20. Then acc_i=0xFF, acc_data=0x02 -> acc_o=0x01.
3. sleep_request pulse -> cpu_state 10 and acc_o frozen. Then wakeup_request pulse -> 11 for exactly 4 cycles, then 01, and accumulation resumes. sleep_request and wakeup_request both high in ACTIVE -> stays 01.
4. spi_data_in=0x08 with a one-cycle spi_start -> spi_busy high for 8 cycles, spi_data_o = 0,0,0,0,1,0,0,0. Then spi_done pulses once and spi_data_o returns to 0.
5. spi_start re-pulsed mid-shift with 0xFF -> ignored, the original 0x08 bits are unchanged. Then 0xA5 started on the done cycle -> 1,0,1,0,0,1,0,1 follows with no gap.
6. Reset asserted at bit 3 of a shift and during WAKEUP -> next edge: spi_busy=0, spi_data_o=0, cpu_state=00.
